// File: rtl/encoder_position_ctrl.sv
// Quadrature position counter with CLEAR/HOME/SNAPSHOT command FSM; CLEAR and SNAP take 1 cycle, HOME waits for index or timeout.
// cmd_ready is high only in IDLE and commands offered while busy are dropped; VELOCITY_MEASURE_EN adds a windowed velocity output.
module encoder_position_ctrl #(
    parameter int COUNT_WIDTH  = 32,
    parameter int HOME_TIMEOUT = 1048576,
    parameter int VEL_PERIOD   = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   count_pulse,
    input  logic                   direction,
    input  logic                   index,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_code,
    output logic                   cmd_ready,
    output logic [COUNT_WIDTH-1:0] position,
    output logic [COUNT_WIDTH-1:0] snap_position,
    output logic                   snap_valid,
    output logic                   homed,
    output logic                   busy,
    output logic                   fault
`ifdef VELOCITY_MEASURE_EN
    ,
    output logic signed [15:0]     velocity
`endif
);

    localparam int HT_W = $clog2(HOME_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CLEAR     = 2'd1;
    localparam logic [1:0] S_HOME_WAIT = 2'd2;
    localparam logic [1:0] S_SNAP      = 2'd3;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_HOME  = 2'b10;
    localparam logic [1:0] CMD_SNAP  = 2'b11;

    generate
        if (COUNT_WIDTH < 2 || HOME_TIMEOUT < 1 || VEL_PERIOD < 1) begin : g_param_check
            $error("encoder_position_ctrl: invalid parameter value");
        end
    endgenerate

    logic [1:0]             r_state;
    logic [COUNT_WIDTH-1:0] r_position;
    logic [COUNT_WIDTH-1:0] r_snap_position;
    logic                   r_snap_valid;
    logic                   r_homed;
    logic                   r_fault;
    logic [HT_W-1:0]        r_home_cnt;
    logic                   r_index_prev;

    logic                   w_accept;
    logic                   w_index_rise;
    logic                   w_home_timeout;
    logic [COUNT_WIDTH-1:0] w_pos_step;
    logic [COUNT_WIDTH-1:0] w_pos_cnt;
    logic [COUNT_WIDTH-1:0] w_pos_next;

    assign w_accept       = cmd_valid && (r_state == S_IDLE);
    assign w_index_rise   = index && !r_index_prev;
    assign w_home_timeout = (r_home_cnt == HT_W'(HOME_TIMEOUT - 1));
    assign w_pos_step     = direction ? COUNT_WIDTH'(1) : {COUNT_WIDTH{1'b1}};
    assign w_pos_cnt      = count_pulse ? (r_position + w_pos_step) : r_position;

    // CLEAR and a homing index edge both override any same-cycle count.
    always_comb begin
        w_pos_next = w_pos_cnt;
        if (r_state == S_CLEAR) begin
            w_pos_next = '0;
        end else if (r_state == S_HOME_WAIT && w_index_rise) begin
            w_pos_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_position      <= '0;
            r_snap_position <= '0;
            r_snap_valid    <= 1'b0;
            r_homed         <= 1'b0;
            r_fault         <= 1'b0;
            r_home_cnt      <= '0;
            r_index_prev    <= 1'b0;
        end else begin
            r_position   <= w_pos_next;
            r_index_prev <= index;
            r_snap_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fault <= 1'b0;
                        case (cmd_code)
                            CMD_CLEAR: r_state <= S_CLEAR;
                            CMD_HOME: begin
                                r_state    <= S_HOME_WAIT;
                                r_home_cnt <= '0;
                            end
                            CMD_SNAP:  r_state <= S_SNAP;
                            CMD_NOP:   r_state <= S_IDLE;
                            default:   r_state <= S_IDLE;
                        endcase
                    end
                end
                S_CLEAR: begin
                    r_homed <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_HOME_WAIT: begin
                    if (w_index_rise) begin
                        r_homed <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_home_timeout) begin
                        r_fault <= 1'b1;
                        r_homed <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_home_cnt <= r_home_cnt + 1'b1;
                    end
                end
                S_SNAP: begin
                    r_snap_position <= w_pos_cnt;
                    r_snap_valid    <= 1'b1;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign position      = r_position;
    assign snap_position = r_snap_position;
    assign snap_valid    = r_snap_valid;
    assign homed         = r_homed;
    assign fault         = r_fault;

`ifdef VELOCITY_MEASURE_EN
    localparam int VW = $clog2(VEL_PERIOD + 1);

    logic [VW-1:0]      r_vel_cnt;
    logic signed [31:0] r_vel_acc;
    logic signed [15:0] r_velocity;
    logic signed [31:0] w_vel_delta;
    logic signed [31:0] w_vel_sum;
    logic signed [15:0] w_vel_sat;

    assign w_vel_delta = count_pulse ? (direction ? 32'sd1 : -32'sd1) : 32'sd0;
    assign w_vel_sum   = r_vel_acc + w_vel_delta;

    always_comb begin
        w_vel_sat = w_vel_sum[15:0];
        if (w_vel_sum > 32'sd32767) begin
            w_vel_sat = 16'sh7fff;
        end else if (w_vel_sum < -32'sd32768) begin
            w_vel_sat = 16'sh8000;
        end
    end

    // Window counter free-runs; the last cycle's pulse belongs to the closing window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vel_cnt  <= '0;
            r_vel_acc  <= '0;
            r_velocity <= '0;
        end else if (r_vel_cnt == VW'(VEL_PERIOD - 1)) begin
            r_vel_cnt  <= '0;
            r_vel_acc  <= '0;
            r_velocity <= w_vel_sat;
        end else begin
            r_vel_cnt <= r_vel_cnt + 1'b1;
            r_vel_acc <= w_vel_sum;
        end
    end

    assign velocity = r_velocity;
`endif

endmodule

// File: tb/tb_encoder_position_ctrl.sv
// Directed bench for encoder_position_ctrl: counting/wrap, CLEAR, HOME success and timeout, SNAPSHOT, reset abort.
module tb_encoder_position_ctrl;

    localparam int CW = 32;
    localparam int HT = 100;
`ifdef VELOCITY_MEASURE_EN
    localparam int VP = 40000;
`else
    localparam int VP = 1000;
`endif

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] CLEAR = 2'b01;
    localparam logic [1:0] HOME  = 2'b10;
    localparam logic [1:0] SNAP  = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          count_pulse = 1'b0;
    logic          direction = 1'b0;
    logic          index = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_code = 2'b00;
    logic          cmd_ready;
    logic [CW-1:0] position;
    logic [CW-1:0] snap_position;
    logic          snap_valid;
    logic          homed;
    logic          busy;
    logic          fault;
`ifdef VELOCITY_MEASURE_EN
    logic signed [15:0] velocity;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    encoder_position_ctrl #(
        .COUNT_WIDTH (CW),
        .HOME_TIMEOUT(HT),
        .VEL_PERIOD  (VP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .count_pulse  (count_pulse),
        .direction    (direction),
        .index        (index),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_ready    (cmd_ready),
        .position     (position),
        .snap_position(snap_position),
        .snap_valid   (snap_valid),
        .homed        (homed),
        .busy         (busy),
        .fault        (fault)
`ifdef VELOCITY_MEASURE_EN
        ,
        .velocity     (velocity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n, input logic dir);
        count_pulse = 1'b1;
        direction   = dir;
        repeat (n) step();
        count_pulse = 1'b0;
    endtask

    task automatic issue(input logic [1:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        step();
        cmd_valid = 1'b0;
        cmd_code  = NOP;
    endtask

    initial begin
        // Reset values while reset is held low
        #2;
        check("rst_position", 64'(position), 64'd0);
        check("rst_snap_pos", 64'(snap_position), 64'd0);
        check("rst_snap_vld", 64'(snap_valid), 64'd0);
        check("rst_homed", 64'(homed), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        reset = 1'b1;
        step();

        // Count and wrap
        pulses(2, 1'b0);
        check("wrap_minus2", 64'(position), 64'hFFFF_FFFE);
        pulses(3, 1'b1);
        check("wrap_up_to_1", 64'(position), 64'd1);
        pulses(2, 1'b0);
        check("wrap_down_all1", 64'(position), 64'hFFFF_FFFF);

        // CLEAR beats a coincident count pulse
        issue(CLEAR);
        check("clear_busy", 64'(busy), 64'd1);
        check("clear_ready_low", 64'(cmd_ready), 64'd0);
        count_pulse = 1'b1;
        direction   = 1'b1;
        step();
        count_pulse = 1'b0;
        check("clear_pos", 64'(position), 64'd0);
        check("clear_idle", 64'(busy), 64'd0);

        // HOME with index edge after 40 cycles, coincident count pulse; commands ignored meanwhile
        pulses(500, 1'b1);
        check("home_pre_pos", 64'(position), 64'd500);
        issue(HOME);
        check("home_busy", 64'(busy), 64'd1);
        issue(CLEAR);
        check("home_cmd_ignored", 64'(position), 64'd500);
        repeat (38) step();
        check("home_still_wait", 64'(busy), 64'd1);
        index       = 1'b1;
        count_pulse = 1'b1;
        direction   = 1'b1;
        step();
        count_pulse = 1'b0;
        check("home_pos0", 64'(position), 64'd0);
        check("home_homed", 64'(homed), 64'd1);
        check("home_idle", 64'(busy), 64'd0);

        // Index edge outside HOME_WAIT is ignored
        index = 1'b0;
        step();
        pulses(5, 1'b1);
        index = 1'b1;
        step();
        index = 1'b0;
        check("idx_ignored_pos", 64'(position), 64'd5);

        // HOME timeout: fault at cycle 101 from command, homed cleared, position kept
        issue(HOME);
        repeat (HT - 1) step();
        check("to_wait_busy", 64'(busy), 64'd1);
        check("to_wait_fault", 64'(fault), 64'd0);
        step();
        check("to_fault", 64'(fault), 64'd1);
        check("to_idle", 64'(busy), 64'd0);
        check("to_homed", 64'(homed), 64'd0);
        check("to_pos_kept", 64'(position), 64'd5);
        repeat (3) step();
        check("to_fault_sticky", 64'(fault), 64'd1);
        issue(CLEAR);
        check("to_fault_cleared", 64'(fault), 64'd0);
        step();
        check("to_clear_pos", 64'(position), 64'd0);

        // SNAPSHOT with up pulse in the SNAP cycle
        pulses(41, 1'b1);
        issue(SNAP);
        check("snap_busy", 64'(busy), 64'd1);
        check("snap_vld_early", 64'(snap_valid), 64'd0);
        count_pulse = 1'b1;
        direction   = 1'b1;
        step();
        count_pulse = 1'b0;
        check("snap_pos", 64'(snap_position), 64'd42);
        check("snap_vld", 64'(snap_valid), 64'd1);
        check("snap_live_pos", 64'(position), 64'd42);
        step();
        check("snap_vld_drop", 64'(snap_valid), 64'd0);
        check("snap_pos_hold", 64'(snap_position), 64'd42);

        // NOP leaves everything idle
        issue(NOP);
        check("nop_idle", 64'(busy), 64'd0);
        check("nop_pos", 64'(position), 64'd42);

        // Reset in the middle of HOME_WAIT
        issue(HOME);
        repeat (10) step();
        reset = 1'b0;
        #1;
        check("mrst_position", 64'(position), 64'd0);
        check("mrst_snap_pos", 64'(snap_position), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_fault", 64'(fault), 64'd0);
        check("mrst_homed", 64'(homed), 64'd0);
`ifdef VELOCITY_MEASURE_EN
        check("mrst_velocity", 64'(velocity), 64'd0);
`endif
        step();
        reset = 1'b1;
        repeat (5) step();
        check("post_rst_idle", 64'(busy), 64'd0);
        check("post_rst_fault", 64'(fault), 64'd0);

`ifdef VELOCITY_MEASURE_EN
        // Nearly a full window of up pulses exceeds the 16-bit range
        pulses(VP, 1'b1);
        check("vel_saturate", 64'(velocity), 64'h7FFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
